// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   state_t  : FSM state encoding (3 bits)
//   wide_t   : wide scratch vector used by the width-generic helpers
//   neg_val  : two's-complement negation
//   abs_val  : magnitude of a w-bit two's-complement value
// Callers widen their operand to wide_t and size-cast the result back to
// their own width. Negation is exact modulo 2^w, so truncation is safe.
package div_pkg;

    localparam int MAX_W = 128;

    typedef logic [MAX_W-1:0] wide_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ITER  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic wide_t neg_val(input wide_t x);
        return ~x + wide_t'(1);
    endfunction

    function automatic wide_t abs_val(input wide_t x, input int w);
        wide_t sh;
        sh = x >> (w - 1);
        return sh[0] ? neg_val(x) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step, purely combinational.
//   a, q   : current partial remainder and quotient/dividend shift register
//   d      : divisor magnitude
//   a_nxt  : partial remainder after the step
//   q_nxt  : shift register after the step, new quotient bit in bit 0
// The caller keeps a < d, so {a, q msb} < 2d and the borrow out of the
// WIDTH+1-bit subtraction is an exact "trial went negative" indicator.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {a, q[WIDTH-1]};
        trial   = shifted - {1'b0, d};
        if (!trial[WIDTH]) begin
            a_nxt = trial[WIDTH-1:0];
        end else begin
            a_nxt = shifted[WIDTH-1:0];
        end
        q_nxt = {q[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/seq_divider.sv
// Multicycle divide unit (DIV/DIVU/REM/REMU), one restoring step per cycle.
//   clk, rst              : clock, synchronous active-high reset
//   start, signed_mode    : request and operand interpretation, sampled on accept
//   dividend, divisor     : operands, sampled on accept
//   busy, done            : handshake; done pulses for one cycle with valid results
//   quotient, remainder   : registered results, held until the next done
//   divby0, overflow      : error flags, set with done, cleared on the next accept
//
// state | meaning
// IDLE  | waiting for start
// CHECK | detect divide-by-zero / signed overflow, else load magnitudes
// ITER  | WIDTH restoring steps, one per cycle
// FIX   | apply signs, write result registers
// DONE  | done pulse; a start here is accepted back-to-back
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divby0,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state_q, state_d;

    // q_r holds the raw dividend until CHECK, then its magnitude, then the
    // unsigned quotient; a_r is the partial remainder.
    logic [WIDTH-1:0] a_r, q_r, d_r;
    logic             smode_r, sn_r, sd_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH-1:0] a_nxt, q_nxt;
    logic             is_div0, is_ovf, last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a     (a_r),
        .q     (q_r),
        .d     (d_r),
        .a_nxt (a_nxt),
        .q_nxt (q_nxt)
    );

    // sn_r is only set in signed mode, so it doubles as the mode qualifier.
    assign is_div0   = (d_r == '0);
    assign is_ovf    = sn_r && (q_r == MIN_VAL) && (d_r == '1);
    assign last_step = (cnt_r == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (is_div0 || is_ovf) state_d = DONE;
                else                   state_d = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (last_step) state_d = FIX;
            end
            FIX: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? CHECK : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            q_r       <= '0;
            d_r       <= '0;
            smode_r   <= 1'b0;
            sn_r      <= 1'b0;
            sd_r      <= 1'b0;
            cnt_r     <= '0;
            quotient  <= '0;
            remainder <= '0;
            divby0    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        q_r      <= dividend;
                        d_r      <= divisor;
                        smode_r  <= signed_mode;
                        sn_r     <= signed_mode & dividend[WIDTH-1];
                        sd_r     <= signed_mode & divisor[WIDTH-1];
                        divby0   <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                CHECK: begin
                    if (is_div0) begin
                        divby0    <= 1'b1;
                        quotient  <= '1;
                        remainder <= q_r;
                    end else if (is_ovf) begin
                        overflow  <= 1'b1;
                        quotient  <= MIN_VAL;
                        remainder <= '0;
                    end else begin
                        if (smode_r) begin
                            q_r <= WIDTH'(abs_val(wide_t'(q_r), WIDTH));
                            d_r <= WIDTH'(abs_val(wide_t'(d_r), WIDTH));
                        end
                        a_r   <= '0;
                        cnt_r <= '0;
                    end
                end
                ITER: begin
                    a_r   <= a_nxt;
                    q_r   <= q_nxt;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                FIX: begin
                    quotient  <= (sn_r ^ sd_r) ? WIDTH'(neg_val(wide_t'(q_r))) : q_r;
                    remainder <= sn_r ? WIDTH'(neg_val(wide_t'(a_r))) : a_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic clk;
    logic rst;

    logic       start8, sm8;
    logic [7:0] dvd8, dvs8;
    logic       busy8, done8, dz8, ov8;
    logic [7:0] q8, r8;

    logic        start32, sm32;
    logic [31:0] dvd32, dvs32;
    logic        busy32, done32, dz32, ov32;
    logic [31:0] q32, r32;

    int n_chk;
    int n_err;

    seq_divider #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .signed_mode (sm8),
        .dividend    (dvd8),
        .divisor     (dvs8),
        .busy        (busy8),
        .done        (done8),
        .quotient    (q8),
        .remainder   (r8),
        .divby0      (dz8),
        .overflow    (ov8)
    );

    seq_divider #(.WIDTH(32)) dut32 (
        .clk         (clk),
        .rst         (rst),
        .start       (start32),
        .signed_mode (sm32),
        .dividend    (dvd32),
        .divisor     (dvs32),
        .busy        (busy32),
        .done        (done32),
        .quotient    (q32),
        .remainder   (r32),
        .divby0      (dz32),
        .overflow    (ov32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; returns in cycle 1 of the operation.
    task automatic start8_op(input logic sm, input logic [7:0] a, input logic [7:0] b);
        sm8 = sm; dvd8 = a; dvs8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    task automatic start32_op(input logic sm, input logic [31:0] a, input logic [31:0] b);
        sm32 = sm; dvd32 = a; dvs32 = b; start32 = 1'b1;
        tick();
        start32 = 1'b0;
    endtask

    task automatic wait8(input int from, output int lat);
        lat = from;
        while (done8 !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait32(input int from, output int lat);
        lat = from;
        while (done32 !== 1'b1 && lat < 80) begin
            tick();
            lat++;
        end
    endtask

    task automatic res8(input string tag, input int lat, input int exp_lat,
                        input logic [7:0] q, input logic [7:0] r,
                        input logic dz, input logic ov);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_q"}, 64'(q8), 64'(q));
        check({tag, "_r"}, 64'(r8), 64'(r));
        check({tag, "_dz"}, 64'(dz8), 64'(dz));
        check({tag, "_ov"}, 64'(ov8), 64'(ov));
    endtask

    // Reference: plain integer division with the architectural corner cases.
    task automatic ref_div(input logic sm, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r,
                           output logic dz, output logic ov);
        longint sa, sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else if (sm && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; ov = 1'b1;
        end else begin
            if (sm) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endtask

    initial begin
        int lat;
        bit saw_done;
        logic [31:0] a, b, eq, er;
        logic esm, edz, eov;
        int sel;

        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        start8 = 0; sm8 = 0; dvd8 = 0; dvs8 = 0;
        start32 = 0; sm32 = 0; dvd32 = 0; dvs32 = 0;
        repeat (3) tick();

        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_q", 64'(q8), 64'd0);
        check("rst_r", 64'(r8), 64'd0);
        check("rst_flags", 64'({dz8, ov8}), 64'd0);
        check("rst_busy32", 64'({busy32, done32, dz32, ov32}), 64'd0);
        rst = 1'b0;
        tick();

        // Unsigned 100/7 with cycle-exact busy profile
        start8_op(1'b0, 8'd100, 8'd7);
        for (int c = 1; c <= 10; c++) begin
            check("t1_busy", 64'({busy8, done8}), 64'b10);
            tick();
        end
        check("t1_done", 64'({busy8, done8}), 64'b01);
        res8("t1", 11, 11, 8'd14, 8'd2, 1'b0, 1'b0);
        tick();
        check("t1_pulse", 64'({busy8, done8}), 64'b00);

        // Signed sign combinations
        start8_op(1'b1, 8'h9C, 8'd7);
        wait8(1, lat);
        res8("t2a", lat, 11, 8'hF2, 8'hFE, 1'b0, 1'b0);
        tick();
        start8_op(1'b1, 8'd100, 8'hF9);
        wait8(1, lat);
        res8("t2b", lat, 11, 8'hF2, 8'h02, 1'b0, 1'b0);
        tick();
        start8_op(1'b1, 8'h9C, 8'hF9);
        wait8(1, lat);
        res8("t2c", lat, 11, 8'h0E, 8'hFE, 1'b0, 1'b0);
        tick();

        // Divide by zero, then the next accept clears the flag
        start8_op(1'b0, 8'h5A, 8'h00);
        wait8(1, lat);
        res8("t3", lat, 2, 8'hFF, 8'h5A, 1'b1, 1'b0);
        tick();
        check("t3_hold_dz", 64'(dz8), 64'd1);
        start8_op(1'b0, 8'd10, 8'd3);
        check("t3_clear_dz", 64'(dz8), 64'd0);
        wait8(1, lat);
        res8("t3n", lat, 11, 8'd3, 8'd1, 1'b0, 1'b0);
        tick();

        // Signed overflow and the same operands unsigned
        start8_op(1'b1, 8'h80, 8'hFF);
        wait8(1, lat);
        res8("t4s", lat, 2, 8'h80, 8'h00, 1'b0, 1'b1);
        tick();
        start8_op(1'b0, 8'h80, 8'hFF);
        wait8(1, lat);
        res8("t4u", lat, 11, 8'h00, 8'h80, 1'b0, 1'b0);
        tick();

        // start while busy is ignored; operand changes after accept too
        start8_op(1'b0, 8'd200, 8'd9);
        repeat (3) tick();
        sm8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd5; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait8(5, lat);
        res8("t5", lat, 11, 8'd22, 8'd2, 1'b0, 1'b0);
        tick();

        // Reset mid-operation
        start8_op(1'b0, 8'd100, 8'd7);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("t5r_busy", 64'(busy8), 64'd0);
        check("t5r_done", 64'(done8), 64'd0);
        check("t5r_q", 64'(q8), 64'd0);
        check("t5r_r", 64'(r8), 64'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
            tick();
        end
        check("t5r_no_done", 64'(saw_done), 64'd0);

        // Back-to-back with start held through DONE
        sm8 = 1'b0; dvd8 = 8'd100; dvs8 = 8'd7; start8 = 1'b1;
        tick();
        wait8(1, lat);
        res8("t6a", lat, 11, 8'd14, 8'd2, 1'b0, 1'b0);
        dvd8 = 8'd255; dvs8 = 8'd16;
        tick();
        start8 = 1'b0;
        check("t6_busy", 64'({busy8, done8}), 64'b10);
        wait8(1, lat);
        res8("t6b", lat, 11, 8'd15, 8'd15, 1'b0, 1'b0);
        tick();

        // Randomised 32-bit operations against the reference model
        for (int i = 0; i < 1500; i++) begin
            a = $urandom();
            b = $urandom();
            esm = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'($urandom_range(1, 15));
                4: a = 32'($urandom_range(0, 100));
                5: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            ref_div(esm, a, b, eq, er, edz, eov);
            start32_op(esm, a, b);
            wait32(1, lat);
            check("rnd_lat", 64'(lat), (edz || eov) ? 64'd2 : 64'd35);
            check("rnd_q", 64'(q32), 64'(eq));
            check("rnd_r", 64'(r32), 64'(er));
            check("rnd_dz", 64'(dz32), 64'(edz));
            check("rnd_ov", 64'(ov32), 64'(eov));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
